// File: rtl/oneshot_multi.sv
// Multi-channel one-shot pulse generator: per-channel trigger synchroniser,
// rising-edge detect, and a programmable-length pulse with optional retrigger.
module oneshot_multi #(
    parameter int CH   = 4,
    parameter int CW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] in,
    input  logic [CW-1:0] len,
    input  logic [CH-1:0] retrig,
    output logic [CH-1:0] enable,
    output logic [CH-1:0] done,
    output logic          busy
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic len_ok;
    assign len_ok = (len != '0);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic          synced;
        logic          prev;
        logic          rise;
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          done_nxt;
        logic          en_q;
        logic          done_q;

        // Flops preset to 1 so a trigger held high through reset never fires.
        if (SYNC > 0) begin : g_sync
            logic [SYNC-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) sync_q <= '1;
                else       sync_q <= (sync_q << 1) | SYNC'(in[c]);
            end
            assign synced = sync_q[SYNC-1];
        end else begin : g_nosync
            assign synced = in[c];
        end

        always_ff @(posedge clk) begin
            if (reset) prev <= 1'b1;
            else       prev <= synced;
        end

        assign rise = synced & ~prev;

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            done_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    if (rise && len_ok) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = len - CW'(1);
                    end
                end
                ACTIVE: begin
                    // An accepted retrigger outranks expiry so enable never gaps.
                    if (retrig[c] && rise && len_ok) begin
                        cnt_nxt = len - CW'(1);
                    end else if (cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                cnt    <= '0;
                en_q   <= 1'b0;
                done_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                en_q   <= (state_nxt == ACTIVE);
                done_q <= done_nxt;
            end
        end

        assign enable[c] = en_q;
        assign done[c]   = done_q;
    end

    assign busy = |enable;

endmodule

// File: tb/tb_oneshot_multi.sv
// Bench for oneshot_multi: directed scenarios plus randomized traffic, all
// checked against a cycles-remaining reference model.
module tb_oneshot_multi;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] in = '0;
    logic [CW-1:0] len = '0;
    logic [CH-1:0] retrig = '0;
    logic [CH-1:0] enable;
    logic [CH-1:0] done;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    // Reference model: input sample history and remaining high cycles per channel.
    bit            hist [CH][SYNC+1];
    int            rem  [CH];
    logic [CH-1:0] exp_en = '0;
    logic [CH-1:0] exp_done = '0;

    oneshot_multi #(.CH(CH), .CW(CW), .SYNC(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .len    (len),
        .retrig (retrig),
        .enable (enable),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            bit r;
            exp_done[c] = 1'b0;
            if (reset) begin
                rem[c] = 0;
                for (int i = 0; i <= SYNC; i++) hist[c][i] = 1'b1;
            end else begin
                r = hist[c][SYNC-1] && !hist[c][SYNC];
                if (rem[c] == 0) begin
                    if (r && len != 0) rem[c] = int'(len);
                end else if (retrig[c] && r && len != 0) begin
                    rem[c] = int'(len);
                end else begin
                    rem[c] = rem[c] - 1;
                    if (rem[c] == 0) exp_done[c] = 1'b1;
                end
                for (int i = SYNC; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = in[c];
            end
            exp_en[c] = (rem[c] > 0);
        end
        #1;
    endtask

    task automatic settle();
        in    = '0;
        reset = 1'b0;
        for (int t = 0; t < 14; t++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in = 4'hF; len = 8'd5; retrig = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            nvec++;
            if (enable !== 4'h0 || done !== 4'h0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state: enable=%b done=%b busy=%b required 0000 0000 0", enable, done, busy);
            end
        end
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            nvec++;
            if (enable !== 4'h0 || done !== 4'h0 || exp_en !== 4'h0) begin
                nerr++;
                $display("FAIL held_high_release t=%0d: enable=%b done=%b required 0000 0000", t, enable, done);
            end
        end
        in = 4'h0;
        for (int t = 0; t < 3; t++) tick();
        in = 4'h1;
        for (int t = 0; t < 8; t++) begin
            tick();
            nvec++;
            if (enable !== exp_en || done !== exp_done || busy !== (|exp_en)) begin
                nerr++;
                $display("FAIL reset_refire_model t=%0d: enable=%b done=%b busy=%b required %b %b %b",
                         t, enable, done, busy, exp_en, exp_done, |exp_en);
            end
            nvec++;
            if (enable !== ((t >= 2 && t <= 6) ? 4'h1 : 4'h0)) begin
                nerr++;
                $display("FAIL reset_refire t=%0d: enable=%b required %b", t, enable,
                         (t >= 2 && t <= 6) ? 4'h1 : 4'h0);
            end
        end
        settle();
    endtask

    task automatic test_single_pulse();
        logic [CH-1:0] want_en, want_done;
        len = 8'd5; retrig = '0;
        for (int t = 0; t < 12; t++) begin
            in = (t <= 3) ? 4'b0010 : 4'b0000;
            tick();
            want_en   = (t >= 2 && t <= 6) ? 4'b0010 : 4'b0000;
            want_done = (t == 7) ? 4'b0010 : 4'b0000;
            nvec++;
            if (enable !== want_en || done !== want_done || busy !== (|want_en)) begin
                nerr++;
                $display("FAIL single_pulse t=%0d: enable=%b done=%b busy=%b required %b %b %b",
                         t, enable, done, busy, want_en, want_done, |want_en);
            end
            nvec++;
            if (enable !== exp_en || done !== exp_done) begin
                nerr++;
                $display("FAIL single_pulse_model t=%0d: enable=%b done=%b required %b %b",
                         t, enable, done, exp_en, exp_done);
            end
        end
        settle();
    endtask

    task automatic test_retrig_last(input bit rt);
        int en_cnt, done_cnt, rises;
        logic last_en;
        en_cnt = 0; done_cnt = 0; rises = 0; last_en = 1'b0;
        len = 8'd4; retrig = rt ? 4'b0100 : 4'b0000;
        for (int t = 0; t < 16; t++) begin
            in = (t == 0 || t == 4) ? 4'b0100 : 4'b0000;
            tick();
            if (enable[2]) en_cnt++;
            if (done[2]) done_cnt++;
            if (enable[2] && !last_en) rises++;
            last_en = enable[2];
            nvec++;
            if (enable !== exp_en || done !== exp_done || busy !== (|exp_en)) begin
                nerr++;
                $display("FAIL retrig_last_model rt=%0d t=%0d: enable=%b done=%b required %b %b",
                         rt, t, enable, done, exp_en, exp_done);
            end
        end
        nvec++;
        if (en_cnt !== (rt ? 8 : 4) || done_cnt !== 1 || rises !== 1) begin
            nerr++;
            $display("FAIL retrig_last rt=%0d: en_cycles=%0d dones=%0d pulses=%0d required %0d 1 1",
                     rt, en_cnt, done_cnt, rises, rt ? 8 : 4);
        end
        settle();
    endtask

    task automatic test_len_change();
        bit want_en, want_done;
        retrig = '0;
        for (int t = 0; t < 32; t++) begin
            in  = ((t <= 3) || (t >= 8 && t <= 20) || (t >= 23)) ? 4'b0001 : 4'b0000;
            len = (t <= 2) ? 8'd3 : ((t <= 22) ? 8'd10 : 8'd0);
            tick();
            want_en   = (t >= 2 && t <= 4) || (t >= 10 && t <= 19);
            want_done = (t == 5) || (t == 20);
            nvec++;
            if (enable !== {3'b000, want_en} || done !== {3'b000, want_done}) begin
                nerr++;
                $display("FAIL len_change t=%0d: enable=%b done=%b required %b %b",
                         t, enable, done, {3'b000, want_en}, {3'b000, want_done});
            end
            nvec++;
            if (enable !== exp_en || done !== exp_done) begin
                nerr++;
                $display("FAIL len_change_model t=%0d: enable=%b done=%b required %b %b",
                         t, enable, done, exp_en, exp_done);
            end
        end
        settle();
    endtask

    task automatic test_all_reset();
        logic [CH-1:0] want_en;
        len = 8'd2; retrig = '0;
        for (int t = 0; t < 12; t++) begin
            in    = 4'hF;
            reset = (t == 4);
            tick();
            want_en = (t == 2 || t == 3) ? 4'hF : 4'h0;
            nvec++;
            if (enable !== want_en || done !== 4'h0 || busy !== (|want_en)) begin
                nerr++;
                $display("FAIL all_reset t=%0d: enable=%b done=%b busy=%b required %b 0000 %b",
                         t, enable, done, busy, want_en, |want_en);
            end
            nvec++;
            if (enable !== exp_en || done !== exp_done) begin
                nerr++;
                $display("FAIL all_reset_model t=%0d: enable=%b done=%b required %b %b",
                         t, enable, done, exp_en, exp_done);
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(2) == 0) in[c] = ~in[c];
            if ($urandom_range(7) == 0) len = CW'($urandom_range(7));
            if ($urandom_range(15) == 0) retrig = CH'($urandom);
            reset = ($urandom_range(99) == 0);
            tick();
            nvec++;
            if (enable !== exp_en || done !== exp_done || busy !== (|exp_en)) begin
                nerr++;
                $display("FAIL random t=%0d: enable=%b done=%b busy=%b required %b %b %b",
                         t, enable, done, busy, exp_en, exp_done, |exp_en);
            end
        end
        settle();
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            rem[c] = 0;
            for (int i = 0; i <= SYNC; i++) hist[c][i] = 1'b1;
        end
        test_reset();
        test_single_pulse();
        test_retrig_last(1'b1);
        test_retrig_last(1'b0);
        test_len_change();
        test_all_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
